// File: rtl/vga_sync_gen.sv
// VGA timing generator: column/row counters, per-axis phase FSMs and registered syncs/strobes.
// Optional frame counter output guarded by the VGA_FRAME_COUNT_EN macro.
module vga_sync_gen #(
  parameter int c_TOTAL_COLS  = 800,
  parameter int c_TOTAL_ROWS  = 525,
  parameter int c_ACTIVE_COLS = 640,
  parameter int c_ACTIVE_ROWS = 480,
  parameter int c_H_FRONT     = 16,
  parameter int c_H_SYNC      = 96,
  parameter int c_V_FRONT     = 10,
  parameter int c_V_SYNC      = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
`ifdef VGA_FRAME_COUNT_EN
  , output logic [7:0] o_Frame_Count
`endif
);

  localparam logic [9:0] LastCol     = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] LastRow     = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] HFrontStart = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] HSyncStart  = 10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] HBackStart  = 10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC);
  localparam logic [9:0] VFrontStart = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] VSyncStart  = 10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] VBackStart  = 10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC);

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} hState_e;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} vState_e;

  logic [9:0] colQ, colD, rowQ, rowD;
  hState_e    hStateQ, hStateD;
  vState_e    vStateQ, vStateD;
  logic       hSyncQ, vSyncQ, activeQ, lineStartQ, frameStartQ;
  logic       colWrap, lineStartD, frameStartD;

  function automatic hState_e decodeH(input logic [9:0] c);
    if (c < HFrontStart)     return H_ACTIVE;
    else if (c < HSyncStart) return H_FRONT;
    else if (c < HBackStart) return H_SYNC;
    else                     return H_BACK;
  endfunction

  function automatic vState_e decodeV(input logic [9:0] r);
    if (r < VFrontStart)     return V_ACTIVE;
    else if (r < VSyncStart) return V_FRONT;
    else if (r < VBackStart) return V_SYNC;
    else                     return V_BACK;
  endfunction

  // Outputs are registered from the next position so every output lines up with the counters.
  always_comb begin
    colWrap     = (colQ == LastCol);
    colD        = colWrap ? 10'd0 : colQ + 10'd1;
    rowD        = rowQ;
    if (colWrap) rowD = (rowQ == LastRow) ? 10'd0 : rowQ + 10'd1;
    lineStartD  = (colD == 10'd0);
    frameStartD = (colD == 10'd0) && (rowD == 10'd0);
  end

  always_comb begin
    hStateD = hStateQ;
    case (hStateQ)
      H_ACTIVE: if (colD == HFrontStart) hStateD = H_FRONT;
      H_FRONT:  if (colD == HSyncStart)  hStateD = H_SYNC;
      H_SYNC:   if (colD == HBackStart)  hStateD = H_BACK;
      H_BACK:   if (colD == 10'd0)       hStateD = H_ACTIVE;
      default:  hStateD = decodeH(colD);
    endcase
  end

  // The vertical phase only moves on the column-wrap cycle, so VSync spans whole lines.
  always_comb begin
    vStateD = vStateQ;
    if (colWrap) begin
      case (vStateQ)
        V_ACTIVE: if (rowD == VFrontStart) vStateD = V_FRONT;
        V_FRONT:  if (rowD == VSyncStart)  vStateD = V_SYNC;
        V_SYNC:   if (rowD == VBackStart)  vStateD = V_BACK;
        V_BACK:   if (rowD == 10'd0)       vStateD = V_ACTIVE;
        default:  vStateD = decodeV(rowD);
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      colQ        <= 10'd0;
      rowQ        <= 10'd0;
      hStateQ     <= H_ACTIVE;
      vStateQ     <= V_ACTIVE;
      hSyncQ      <= 1'b1;
      vSyncQ      <= 1'b1;
      activeQ     <= 1'b0;
      lineStartQ  <= 1'b0;
      frameStartQ <= 1'b0;
    end else begin
      colQ        <= colD;
      rowQ        <= rowD;
      hStateQ     <= hStateD;
      vStateQ     <= vStateD;
      hSyncQ      <= (hStateD != H_SYNC);
      vSyncQ      <= (vStateD != V_SYNC);
      activeQ     <= (hStateD == H_ACTIVE) && (vStateD == V_ACTIVE);
      lineStartQ  <= lineStartD;
      frameStartQ <= frameStartD;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frameCountQ;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)         frameCountQ <= 8'd0;
    else if (frameStartD) frameCountQ <= frameCountQ + 8'd1;
  end

  assign o_Frame_Count = frameCountQ;
`else
  // Without the frame counter the strobes alone mark frame boundaries.
`endif

  assign o_HSync       = hSyncQ;
  assign o_VSync       = vSyncQ;
  assign o_Active      = activeQ;
  assign o_Col_Count   = colQ;
  assign o_Row_Count   = rowQ;
  assign o_Line_Start  = lineStartQ;
  assign o_Frame_Start = frameStartQ;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running VGA timing generator that produces the HSync/VSync pulses consumed by the game top-level (`frogger_game`) and its `Sync_To_Count` stage. It also produces the matching column/row counters, an active-video flag and line/frame strobes. Each axis is driven by a counter plus a four-phase state machine (active, front porch, sync, back porch). Defaults are 640x480 at 60 Hz from a 25.175 MHz pixel clock.

## Interface
Parameters:
- `c_TOTAL_COLS`, 800, clocks per line
- `c_TOTAL_ROWS`, 525, lines per frame
- `c_ACTIVE_COLS`, 640, visible columns
- `c_ACTIVE_ROWS`, 480, visible rows
- `c_H_FRONT`, 16, horizontal front porch (clocks)
- `c_H_SYNC`, 96, horizontal sync width (clocks)
- `c_V_FRONT`, 10, vertical front porch (lines)
- `c_V_SYNC`, 2, vertical sync width (lines)
- Horizontal back porch = `c_TOTAL_COLS - c_ACTIVE_COLS - c_H_FRONT - c_H_SYNC` (48). Vertical back porch derived the same way (33).

Ports:
- `i_Clk`  in  1  pixel clock (one clock only)
- `i_Rst_L`  in  1  reset, asynchronous, active-low
- `o_HSync`  out  1  horizontal sync, active-low
- `o_VSync`  out  1  vertical sync, active-low
- `o_Active`  out  1  high when both axes are in their active phase
- `o_Col_Count`  out  10  current column, 0..c_TOTAL_COLS-1
- `o_Row_Count`  out  10  current row, 0..c_TOTAL_ROWS-1
- `o_Line_Start`  out  1  one-cycle strobe when column is 0
- `o_Frame_Start`  out  1  one-cycle strobe when column is 0 and row is 0
- `o_Frame_Count`  out  8  frame counter; present only with `VGA_FRAME_COUNT_EN`

## Operation
- Column counter increments every clock and wraps from c_TOTAL_COLS-1 to 0.
- Row counter increments only on that column wrap. It wraps from c_TOTAL_ROWS-1 to 0.
- Horizontal FSM states, with a transition when the next column value crosses each boundary:
  - H_ACTIVE: cols 0..639
  - H_FRONT: cols 640..655
  - H_SYNC: cols 656..751
  - H_BACK: cols 752..799, then back to H_ACTIVE
- Vertical FSM uses the same four states, keyed on row:
  - V_ACTIVE: rows 0..479
  - V_FRONT: rows 480..489
  - V_SYNC: rows 490..491
  - V_BACK: rows 492..524
- The vertical FSM advances only on the column-wrap cycle.
- Output decoding:
  - `o_HSync` = 0 only in H_SYNC.
  - `o_VSync` = 0 only in V_SYNC, for whole lines (falls and rises together with the column wrap).
  - `o_Active` = H_ACTIVE and V_ACTIVE.
- FSM state must always equal the state decoded from the counters. An illegal state encoding recovers to the decoded state within one clock.
- Width rule: counters are 10 bits. Parameters must satisfy c_TOTAL_COLS ≤ 1024 and c_TOTAL_ROWS ≤ 1024. Porch/sync sums exceeding the total are a configuration error and are not handled.

## Timing
- All outputs are registered and mutually aligned: in the cycle where `o_Col_Count`=N and `o_Row_Count`=M, every other output reflects position (N,M).
- Latency from reset release to first valid position: one clock.
- Reset values (held while `i_Rst_L`=0, applied asynchronously):
  - `o_Col_Count`=0, `o_Row_Count`=0
  - `o_HSync`=1, `o_VSync`=1
  - `o_Active`=0, `o_Line_Start`=0, `o_Frame_Start`=0, `o_Frame_Count`=0
  - both FSMs in their ACTIVE state
- Reset release: the first rising edge after release shows column 1, row 0, `o_Active`=1. Pixel (0,0) of the first frame is therefore blanked and produces no strobes. The first `o_Frame_Start` occurs one full frame later.
- Reset asserted mid-line or mid-frame: all outputs go immediately to their reset values, including a sync pulse in progress, which ends immediately (sync returns to 1).
- Line period is 800 clocks; frame period is 420000 clocks.
- `o_Frame_Start` and `o_Line_Start` coincide at (0,0).

## Configuration
- Macro `VGA_FRAME_COUNT_EN` defined:
  - `o_Frame_Count` port exists.
  - It increments in the same cycle `o_Frame_Start` is high (the count shows the new value with the strobe) and wraps 255 -> 0.
  - Intended as the game tick source.
- Macro undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Release reset, run 800 clocks -> `o_HSync` low exactly for cols 656..751 (96 clocks), high otherwise; `o_Active` high for cols 1..639 of row 0.
- Run 2 frames -> `o_VSync` low for rows 490..491 (1600 clocks); `o_Frame_Start` pulses exactly 420000 clocks apart; `o_Line_Start` pulses 525 times per frame.
- Check rows 480..524 -> `o_Active`=0 for every column; rows 0..479 -> `o_Active`=1 only for cols 0..639 (after the first frame).
- Assert `i_Rst_L`=0 at col 700, row 491 (mid-sync) -> same-cycle outputs reset (`o_HSync`=1, `o_VSync`=1, counts 0); release -> col 1, row 0 on the first edge.
- Column/row wrap -> col 799 followed by col 0 with row+1; (799,524) followed by (0,0) with `o_Frame_Start`=1.
- With `VGA_FRAME_COUNT_EN` defined, run 257 frames -> `o_Frame_Count` goes 1..255, 0, 1; without the macro the bench compiles without the port.
